// File: rtl/rotor_stepper.sv
// rtl/rotor_stepper.sv - Enigma rotor position stage: one key per handshake, notch carry with double step.
module rotor_stepper #(
   parameter logic [4:0] NOTCH_L = 5'd16,
   parameter logic [4:0] NOTCH_M = 5'd4,
   parameter logic [4:0] NOTCH_R = 5'd21
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic       key_valid,
   output logic       key_ready,
   input  logic [7:0] key_char,
   input  logic       load,
   input  logic [4:0] load_l,
   input  logic [4:0] load_m,
   input  logic [4:0] load_r,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] out_char,
   output logic [4:0] pos_l,
   output logic [4:0] pos_m,
   output logic [4:0] pos_r
);

   typedef enum logic {S_IDLE = 1'b0, S_EMIT = 1'b1} state_t;

   state_t     state_q;
   logic       out_valid_q;
   logic [7:0] out_char_q;
   logic [4:0] pos_l_q, pos_m_q, pos_r_q;
   logic [4:0] pos_l_d, pos_m_d, pos_r_d;
   logic       mid_at_notch, right_at_notch;

   function automatic logic [4:0] inc26(input logic [4:0] x);
      return (x == 5'd25) ? 5'd0 : x + 5'd1;
   endfunction

   function automatic logic [4:0] clamp26(input logic [4:0] x);
      return (x > 5'd25) ? 5'd0 : x;
   endfunction

   // Middle rotor at its own notch steps again (double step) and carries into the left rotor.
   always_comb begin
      mid_at_notch   = (pos_m_q == NOTCH_M);
      right_at_notch = (pos_r_q == NOTCH_R);
      pos_r_d        = inc26(pos_r_q);
      pos_m_d        = (right_at_notch || mid_at_notch) ? inc26(pos_m_q) : pos_m_q;
      pos_l_d        = mid_at_notch ? inc26(pos_l_q) : pos_l_q;
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q     <= S_IDLE;
         out_valid_q <= 1'b0;
         out_char_q  <= 8'h00;
         pos_l_q     <= 5'd0;
         pos_m_q     <= 5'd0;
         pos_r_q     <= 5'd0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (load) begin
                  pos_l_q <= clamp26(load_l);
                  pos_m_q <= clamp26(load_m);
                  pos_r_q <= clamp26(load_r);
               end else if (key_valid) begin
                  out_char_q  <= key_char;
                  pos_l_q     <= pos_l_d;
                  pos_m_q     <= pos_m_d;
                  pos_r_q     <= pos_r_d;
                  out_valid_q <= 1'b1;
                  state_q     <= S_EMIT;
               end
            end
            S_EMIT: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= S_IDLE;
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               state_q     <= S_IDLE;
            end
         endcase
      end
   end

   // The left notch never carries; it is only range-checked alongside the others.
   always_ff @(posedge clock) begin
      if (resetn) begin
         assert (NOTCH_L < 5'd26 && NOTCH_M < 5'd26 && NOTCH_R < 5'd26);
      end
   end

   assign key_ready = (state_q == S_IDLE) && !load;
   assign out_valid = out_valid_q;
   assign out_char  = out_char_q;
   assign pos_l     = pos_l_q;
   assign pos_m     = pos_m_q;
   assign pos_r     = pos_r_q;

endmodule

// File: tb/tb_rotor_stepper.sv
// tb/tb_rotor_stepper.sv - scoreboard bench for rotor_stepper with directed key/load vectors.
module tb_rotor_stepper;

   logic       clock;
   logic       resetn;
   logic       key_valid;
   logic       key_ready;
   logic [7:0] key_char;
   logic       load;
   logic [4:0] load_l, load_m, load_r;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_char;
   logic [4:0] pos_l, pos_m, pos_r;

   typedef struct packed {
      logic [7:0] c;
      logic [4:0] l;
      logic [4:0] m;
      logic [4:0] r;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   rotor_stepper dut (
      .clock     (clock),
      .resetn    (resetn),
      .key_valid (key_valid),
      .key_ready (key_ready),
      .key_char  (key_char),
      .load      (load),
      .load_l    (load_l),
      .load_m    (load_m),
      .load_r    (load_r),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_char  (out_char),
      .pos_l     (pos_l),
      .pos_m     (pos_m),
      .pos_r     (pos_r)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk_pos(input string name, input logic [4:0] l, input logic [4:0] m, input logic [4:0] r);
      chk(name, {pos_l, pos_m, pos_r}, {l, m, r});
   endtask

   // Monitor: each output transfer pops one expected entry.
   always @(negedge clock) begin
      if (resetn && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_output", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("out_char", out_char, e.c);
            chk("out_pos", {pos_l, pos_m, pos_r}, {e.l, e.m, e.r});
         end
      end
   end

   task automatic do_load(input logic [4:0] l, input logic [4:0] m, input logic [4:0] r,
                          input logic [4:0] el, input logic [4:0] em, input logic [4:0] er);
      load = 1'b1; load_l = l; load_m = m; load_r = r;
      #1;
      chk("key_ready_during_load", key_ready, 1'b0);
      tick();
      load = 1'b0;
      #1;
      chk_pos("load_pos", el, em, er);
   endtask

   // Accept one key; returns with the DUT in EMIT.
   task automatic send_key(input logic [7:0] c, input logic [4:0] el, input logic [4:0] em, input logic [4:0] er);
      key_valid = 1'b1; key_char = c;
      #1;
      chk("key_ready_idle", key_ready, 1'b1);
      exp_q.push_back('{c: c, l: el, m: em, r: er});
      tick();
      key_valid = 1'b0;
      chk("out_valid_after_accept", out_valid, 1'b1);
      chk("key_ready_in_emit", key_ready, 1'b0);
   endtask

   task automatic key_drain(input logic [7:0] c, input logic [4:0] el, input logic [4:0] em, input logic [4:0] er);
      send_key(c, el, em, er);
      tick();
      chk("out_valid_after_emit", out_valid, 1'b0);
      chk("key_ready_back_idle", key_ready, 1'b1);
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      resetn = 1'b0; key_valid = 1'b0; key_char = 8'h00; load = 1'b0;
      load_l = 5'd0; load_m = 5'd0; load_r = 5'd0; out_ready = 1'b1;
      #2;
      chk("reset_key_ready", key_ready, 1'b1);
      chk("reset_out_valid", out_valid, 1'b0);
      chk("reset_out_char", out_char, 8'h00);
      chk_pos("reset_pos", 5'd0, 5'd0, 5'd0);
      tick(); tick();
      resetn = 1'b1;
      tick();

      // Single step
      key_drain(8'h48, 5'd0, 5'd0, 5'd1);

      // Notch carry
      do_load(5'd0, 5'd0, 5'd21, 5'd0, 5'd0, 5'd21);
      key_drain(8'h41, 5'd0, 5'd1, 5'd22);

      // Double step ADV -> AEW -> BFX -> BFY
      do_load(5'd0, 5'd3, 5'd21, 5'd0, 5'd3, 5'd21);
      key_drain(8'h42, 5'd0, 5'd4, 5'd22);
      key_drain(8'h43, 5'd1, 5'd5, 5'd23);
      key_drain(8'h44, 5'd1, 5'd5, 5'd24);

      // Wrap and load clamp
      do_load(5'd25, 5'd25, 5'd25, 5'd25, 5'd25, 5'd25);
      key_drain(8'h57, 5'd25, 5'd25, 5'd0);
      do_load(5'd30, 5'd3, 5'd26, 5'd0, 5'd3, 5'd0);

      // Backpressure with key_valid/load toggling
      out_ready = 1'b0;
      send_key(8'h5A, 5'd0, 5'd3, 5'd1);
      for (int i = 0; i < 5; i++) begin
         key_valid = i[0]; load = ~i[0]; key_char = 8'h51;
         load_l = 5'd7; load_m = 5'd7; load_r = 5'd7;
         #1;
         chk("bp_key_ready", key_ready, 1'b0);
         chk("bp_out_valid", out_valid, 1'b1);
         chk("bp_out_char", out_char, 8'h5A);
         chk_pos("bp_pos", 5'd0, 5'd3, 5'd1);
         tick();
      end
      key_valid = 1'b0; load = 1'b0;
      out_ready = 1'b1;
      tick();
      chk("bp_release_out_valid", out_valid, 1'b0);
      chk("bp_release_key_ready", key_ready, 1'b1);
      chk_pos("bp_release_pos", 5'd0, 5'd3, 5'd1);

      // Load beats key in the same cycle
      key_valid = 1'b1; key_char = 8'h4B;
      do_load(5'd2, 5'd9, 5'd21, 5'd2, 5'd9, 5'd21);
      key_valid = 1'b0;
      chk("load_prio_out_valid", out_valid, 1'b0);
      key_drain(8'h4B, 5'd2, 5'd10, 5'd22);

      // Reset while in EMIT discards the captured key
      out_ready = 1'b0;
      send_key(8'h52, 5'd2, 5'd10, 5'd23);
      #2;
      resetn = 1'b0;
      #1;
      void'(exp_q.pop_back());
      chk("rst_emit_out_valid", out_valid, 1'b0);
      chk("rst_emit_out_char", out_char, 8'h00);
      chk_pos("rst_emit_pos", 5'd0, 5'd0, 5'd0);
      chk("rst_emit_key_ready", key_ready, 1'b1);
      tick();
      resetn = 1'b1;
      out_ready = 1'b1;
      tick();
      key_drain(8'h45, 5'd0, 5'd0, 5'd1);

      tick();
      chk("scoreboard_empty", exp_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
